row_scan_ctrl: RTL and testbench
================================

Name: row_scan_ctrl

Overview:
Sequencer for the paired-row decoder of the crossbar array. Steps a row window [first_row..last_row] one row at a time: drives the decoder enable and row select, waits a programmable settle time, then handshakes a sample request with the column readout. Sits between the top-level command logic and the row decoder / column sense path.

Parameters:
PAIR_ROW_NO, 64, number of paired rows in the array; ROW_W = $clog2(PAIR_ROW_NO)
SETTLE_CYC, 4, cycles a row is driven before sampling; legal range 1..255
ACK_TIMEOUT, 16, maximum cycles sample_req may wait for sample_ack; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle scan request; sampled only in IDLE
abort  in  1  terminate an active scan
first_row  in  ROW_W  first row of the window; latched on accepted start
last_row  in  ROW_W  last row of the window; latched on accepted start
row_en  out  1  decoder enable
row_sel  out  ROW_W  decoder row index
sample_req  out  1  request to the column readout to sample the current row
sample_ack  in  1  readout has taken the sample; valid only while sample_req=1
cur_row  out  ROW_W  row being sampled; valid while sample_req=1
busy  out  1  high from the cycle after an accepted start through the DONE cycle
done  out  1  one-cycle pulse: window completed normally
err  out  1  one-cycle pulse: bad window, ack timeout, or abort

Behaviour:
- All outputs are registered. Reset values: row_en=0, row_sel=0, sample_req=0, cur_row=0, busy=0, done=0, err=0, state=IDLE, counters=0.
- rst asserted mid-scan forces the reset values immediately; no done or err pulse is produced.
- States: IDLE, SETTLE, SAMPLE, DONE, FAIL.
- IDLE, start=1:
  - first_row>last_row: go to FAIL. No row is ever enabled.
  - otherwise: latch the window, row_sel<=first_row, row_en<=1, busy<=1, settle_cnt<=0, go to SETTLE.
- SETTLE: row_en=1, row_sel held. settle_cnt increments each cycle. After SETTLE_CYC cycles in SETTLE, go to SAMPLE with sample_req<=1, cur_row<=row_sel, wait_cnt<=0.
- The decoder registers its output one cycle after row_en/row_sel change. That cycle is included in SETTLE_CYC.
- SAMPLE: sample_req held at 1 until a cycle with sample_ack=1. On ack:
  - sample_req<=0.
  - row_sel==last_row: go to DONE with row_en<=0.
  - otherwise: row_sel<=row_sel+1, row_en stays 1, settle_cnt<=0, go to SETTLE.
- sample_ack while sample_req=0 is ignored.
- Timeout: wait_cnt counts SAMPLE cycles without ack. When it reaches ACK_TIMEOUT, go to FAIL.
- DONE: done=1 and busy=1 for one cycle, then IDLE with busy=0.
- FAIL: err=1 for one cycle; row_en=0, sample_req=0. Then IDLE with busy=0.
- abort=1 in SETTLE or SAMPLE: go to FAIL. Abort has priority over a simultaneous sample_ack.
- abort in IDLE, DONE or FAIL has no effect.
- start while busy is ignored; the window inputs are not re-latched.
- No wrap-around: the row increment is never taken at last_row, so last_row=PAIR_ROW_NO-1 completes without overflow.
- first_row==last_row is a legal single-row scan.
- Timing, immediate ack, start accepted in cycle 0:
  - row k sampled in cycle k*(SETTLE_CYC+1)+SETTLE_CYC+1
  - done in cycle N*(SETTLE_CYC+1)+1, for N rows

Decomposition:
- Shared package row_pkg:
  - ROW_W derivation from PAIR_ROW_NO
  - scan_state_t enum {IDLE, SETTLE, SAMPLE, DONE, FAIL}
  - counter width constant CNT_W=8
- One natural sub-module, cyc_cnt: a clear/enable counter with a terminal-count flag. It is instantiated twice, once for settle_cnt and once for wait_cnt.
- The FSM and datapath stay in row_scan_ctrl.

Test Plan:
- Single row, bad window and start-while-busy:
  - rst, then start with first_row=5, last_row=5, SETTLE_CYC=4, ack tied 1 -> row_en=1, row_sel=5 in cycles 1-5; sample_req=1, cur_row=5 in cycle 5; done pulse in cycle 6; err never asserted.
  - start with first_row=9, last_row=3 -> err pulse in cycle 1; row_en stays 0; busy stays 0; done never asserted.
  - start pulse while busy -> no effect; window unchanged.
- Full array: window 0..63, ack tied 1 -> exactly 64 sample_req cycles with cur_row 0..63 in order; done in cycle 64*5+1=321; row_sel never wraps.
- Delayed ack and timeout:
  - window 10..12, ack asserted 3 cycles after each sample_req -> three samples; sample_req held through each wait; row_sel steps 10→11→12; single done pulse.
  - window 2..4, ack never asserted, ACK_TIMEOUT=16 -> err after 16 SAMPLE cycles on row 2; row_en=0 and sample_req=0 the next cycle.
- Abort: abort in the same cycle as sample_ack on row 7 of window 6..9 -> err pulse, no done; row 8 never enabled.
- Async reset: rst asserted mid-SETTLE on row 20 -> row_en, sample_req and busy drop to 0 without a clock edge; a following start runs normally.

Source files
------------

// File: rtl/row_pkg.sv
// Shared types and constants for the paired-row scan sequencer.
package row_pkg;

   localparam int CNT_W = 8;

   // Row index width for an array of n paired rows; never narrower than one bit.
   function automatic int row_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE,
      FAIL
   } scan_state_t;

endpackage

// File: rtl/cyc_cnt.sv
// Clear/enable cycle counter with a terminal-count flag at a programmable value.
module cyc_cnt
   import row_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] tc_val,
   output logic         tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tc = (cnt == tc_val);

endmodule

// File: rtl/row_scan_ctrl.sv
// Row-window sequencer: enables one decoder row at a time, waits for it to settle,
// then handshakes a sample request with the column readout.
module row_scan_ctrl
   import row_pkg::*;
#(
   parameter  int PAIR_ROW_NO = 64,
   parameter  int SETTLE_CYC  = 4,
   parameter  int ACK_TIMEOUT = 16,
   localparam int ROW_W       = row_w(PAIR_ROW_NO)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [ROW_W-1:0] first_row,
   input  logic [ROW_W-1:0] last_row,
   output logic             row_en,
   output logic [ROW_W-1:0] row_sel,
   output logic             sample_req,
   input  logic             sample_ack,
   output logic [ROW_W-1:0] cur_row,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] ACK_TC    = CNT_W'(ACK_TIMEOUT - 1);

   scan_state_t      state;
   logic [ROW_W-1:0] last_q;
   logic             settle_tc;
   logic             wait_tc;

   // Each counter restarts from zero whenever its state is entered.
   cyc_cnt #(.W(CNT_W)) u_settle_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != SETTLE),
      .en     (state == SETTLE),
      .tc_val (SETTLE_TC),
      .tc     (settle_tc)
   );

   cyc_cnt #(.W(CNT_W)) u_wait_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (state != SAMPLE),
      .en     (state == SAMPLE),
      .tc_val (ACK_TC),
      .tc     (wait_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         row_en     <= 1'b0;
         row_sel    <= '0;
         sample_req <= 1'b0;
         cur_row    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         last_q     <= '0;
      end else begin
         // NOTE: pulse outputs default low here and are raised only on the transition
         // into DONE/FAIL, so each stays high for exactly one cycle.
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (first_row > last_row) begin
                     err   <= 1'b1;
                     state <= FAIL;
                  end else begin
                     last_q  <= last_row;
                     row_sel <= first_row;
                     row_en  <= 1'b1;
                     busy    <= 1'b1;
                     state   <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (abort) begin
                  err    <= 1'b1;
                  row_en <= 1'b0;
                  busy   <= 1'b0;
                  state  <= FAIL;
               end else if (settle_tc) begin
                  sample_req <= 1'b1;
                  cur_row    <= row_sel;
                  state      <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (abort || (!sample_ack && wait_tc)) begin
                  err        <= 1'b1;
                  row_en     <= 1'b0;
                  sample_req <= 1'b0;
                  busy       <= 1'b0;
                  state      <= FAIL;
               end else if (sample_ack) begin
                  sample_req <= 1'b0;
                  // Increment is never taken at last_row, so the top row cannot wrap.
                  if (row_sel == last_q) begin
                     row_en <= 1'b0;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     row_sel <= row_sel + 1'b1;
                     state   <= SETTLE;
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            FAIL: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_row_scan_ctrl.sv
// Self-checking bench for row_scan_ctrl: expected traces are built from the
// scan timing rules as per-cycle schedules, then compared cycle by cycle.
module tb_row_scan_ctrl;

   localparam int PAIR_ROW_NO = 64;
   localparam int SETTLE_CYC  = 4;
   localparam int ACK_TIMEOUT = 16;
   localparam int ROW_W       = 6;
   localparam int MAXC        = 4096;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic             sample_ack = 1'b0;
   logic [ROW_W-1:0] first_row = '0;
   logic [ROW_W-1:0] last_row = '0;
   logic             row_en;
   logic [ROW_W-1:0] row_sel;
   logic             sample_req;
   logic [ROW_W-1:0] cur_row;
   logic             busy;
   logic             done;
   logic             err;

   row_scan_ctrl #(
      .PAIR_ROW_NO (PAIR_ROW_NO),
      .SETTLE_CYC  (SETTLE_CYC),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .first_row  (first_row),
      .last_row   (last_row),
      .row_en     (row_en),
      .row_sel    (row_sel),
      .sample_req (sample_req),
      .sample_ack (sample_ack),
      .cur_row    (cur_row),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Expected per-cycle trace of one scan; cycle 0 is the cycle start is accepted.
   bit e_en[MAXC];
   int e_sel[MAXC];
   bit e_req[MAXC];
   int e_cur[MAXC];
   bit e_busy[MAXC];
   bit e_busy_chk[MAXC];
   bit e_done[MAXC];
   bit e_err[MAXC];
   bit ack_at[MAXC];
   bit abort_at[MAXC];
   int delay[PAIR_ROW_NO];
   int len;

   // Ack delay per row (cycles after sample_req rises); >= ACK_TIMEOUT means never.
   task automatic build(input int f, input int l, input int abort_row, input int abort_cyc);
      int t, s, d, a, fin;
      for (int c = 0; c < MAXC; c++) begin
         e_en[c] = 0; e_sel[c] = 0; e_req[c] = 0; e_cur[c] = 0;
         e_busy[c] = 0; e_busy_chk[c] = 1; e_done[c] = 0; e_err[c] = 0;
         ack_at[c] = 0; abort_at[c] = 0;
      end
      if (f > l) begin
         e_err[1] = 1;
         len = 2;
         return;
      end
      a   = abort_cyc;
      t   = 1;
      fin = 0;
      for (int k = f; k <= l; k++) begin
         s = t + SETTLE_CYC;
         d = delay[k - f];
         if (d >= ACK_TIMEOUT) begin
            for (int c = t; c < s + ACK_TIMEOUT; c++) begin
               e_en[c] = 1; e_sel[c] = k; e_busy[c] = 1;
            end
            for (int c = s; c < s + ACK_TIMEOUT; c++) begin
               e_req[c] = 1; e_cur[c] = k;
            end
            fin = s + ACK_TIMEOUT;
            e_err[fin] = 1;
            e_busy_chk[fin] = 0;
            break;
         end
         for (int c = t; c <= s + d; c++) begin
            e_en[c] = 1; e_sel[c] = k; e_busy[c] = 1;
         end
         for (int c = s; c <= s + d; c++) begin
            e_req[c] = 1; e_cur[c] = k;
         end
         ack_at[s + d] = 1;
         if (k == abort_row) a = s + d;
         t = s + d + 1;
         if (k == l) begin
            fin = t;
            e_done[fin] = 1;
            e_busy[fin] = 1;
         end
      end
      if (a > 0 && a < fin) begin
         for (int c = a + 1; c < MAXC; c++) begin
            e_en[c] = 0; e_sel[c] = 0; e_req[c] = 0; e_cur[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0; ack_at[c] = 0;
         end
         e_err[a + 1] = 1;
         e_busy_chk[a + 1] = 0;
         abort_at[a] = 1;
         fin = a + 1;
      end
      len = fin + 1;
   endtask

   task automatic run_scan(input int f, input int l, input int abort_row, input int abort_cyc,
                           input string name);
      build(f, l, abort_row, abort_cyc);
      @(negedge clk);
      first_row  = ROW_W'(f);
      last_row   = ROW_W'(l);
      start      = 1'b1;
      abort      = 1'b0;
      sample_ack = 1'($urandom_range(0, 1));
      for (int c = 1; c <= len; c++) begin
         @(negedge clk);
         check($sformatf("%s c%0d row_en", name, c), 32'(row_en), 32'(e_en[c]));
         if (e_en[c]) check($sformatf("%s c%0d row_sel", name, c), 32'(row_sel), e_sel[c]);
         check($sformatf("%s c%0d sample_req", name, c), 32'(sample_req), 32'(e_req[c]));
         if (e_req[c]) check($sformatf("%s c%0d cur_row", name, c), 32'(cur_row), e_cur[c]);
         if (e_busy_chk[c]) check($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(e_busy[c]));
         check($sformatf("%s c%0d done", name, c), 32'(done), 32'(e_done[c]));
         check($sformatf("%s c%0d err", name, c), 32'(err), 32'(e_err[c]));
         // Stray starts with a fresh window while the scan is still active must be ignored.
         start = (c < len) && ($urandom_range(0, 3) == 0);
         if (start) begin
            first_row = ROW_W'($urandom);
            last_row  = ROW_W'($urandom);
         end
         abort      = abort_at[c] || ((e_done[c] || e_err[c]) && ($urandom_range(0, 1) == 1));
         sample_ack = e_req[c] ? ack_at[c] : 1'($urandom_range(0, 1));
      end
      start      = 1'b0;
      abort      = 1'b0;
      sample_ack = 1'b0;
   endtask

   task automatic set_delays(input int d);
      for (int i = 0; i < PAIR_ROW_NO; i++) delay[i] = d;
   endtask

   initial begin
      int f, l, ab;
      set_delays(0);
      repeat (3) @(negedge clk);
      check("reset row_en", 32'(row_en), 0);
      check("reset row_sel", 32'(row_sel), 0);
      check("reset sample_req", 32'(sample_req), 0);
      check("reset cur_row", 32'(cur_row), 0);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset err", 32'(err), 0);
      rst = 1'b0;

      run_scan(5, 5, -1, 0, "single");
      run_scan(9, 3, -1, 0, "bad_window");
      run_scan(0, 63, -1, 0, "full");
      set_delays(3);
      run_scan(10, 12, -1, 0, "delayed_ack");
      set_delays(99);
      run_scan(2, 4, -1, 0, "timeout");
      set_delays(1);
      run_scan(6, 9, 7, 0, "abort_ack");

      // Asynchronous reset in the middle of row 20's settle window.
      @(negedge clk);
      first_row = 6'd20;
      last_row  = 6'd30;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("pre_rst row_en", 32'(row_en), 1);
      check("pre_rst row_sel", 32'(row_sel), 20);
      check("pre_rst busy", 32'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst row_en", 32'(row_en), 0);
      check("async_rst row_sel", 32'(row_sel), 0);
      check("async_rst sample_req", 32'(sample_req), 0);
      check("async_rst busy", 32'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      set_delays(0);
      run_scan(20, 22, -1, 0, "after_rst");

      for (int n = 0; n < 40; n++) begin
         f = $urandom_range(0, PAIR_ROW_NO - 1);
         l = $urandom_range(0, PAIR_ROW_NO - 1);
         if (f > l && $urandom_range(0, 7) != 0) begin
            int tmp;
            tmp = f; f = l; l = tmp;
         end
         for (int i = 0; i < PAIR_ROW_NO; i++)
            delay[i] = ($urandom_range(0, 29) == 0) ? 20 : $urandom_range(0, 4);
         ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 60) : 0;
         run_scan(f, l, -1, ab, $sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
